// File: rtl/pulse_period_meter.sv
// Measures high time, low time and period of a synchronous pulse train in clk cycles,
// strobing valid once per completed cycle and flagging saturation and period lock.
module pulse_period_meter #(
  parameter int W          = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_in,
  output logic [W-1:0] high_width,
  output logic [W-1:0] low_width,
  output logic [W:0]   period,
  output logic         valid,
  output logic         ovf,
  output logic         locked
);

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  state_t       state_q;
  logic         p_q;
  logic [W-1:0] cnt_q;
  logic         sat_q;
  logic [W-1:0] hi_hold_q;
  logic         hi_sat_q;
  logic [3:0]   match_q;

  logic         rise;
  logic         fall;
  logic         cnt_max;
  logic [W-1:0] cnt_d;
  logic         sat_d;
  logic [W:0]   period_d;
  logic         ovf_d;
  logic [3:0]   match_d;

  assign rise     = pulse_in & ~p_q;
  assign fall     = ~pulse_in & p_q;
  assign cnt_max  = (cnt_q == {W{1'b1}});
  // The counter holds at all-ones; an increment attempted there marks the level as saturated.
  assign cnt_d    = cnt_max ? cnt_q : cnt_q + W'(1);
  assign sat_d    = sat_q | cnt_max;
  assign period_d = {1'b0, hi_hold_q} + {1'b0, cnt_q};
  assign ovf_d    = hi_sat_q | sat_q;

  always_comb begin
    match_d = 4'd1;
    if (ovf_d) begin
      match_d = 4'd0;
    end else if ((match_q != 4'd0) && (period_d == period)) begin
      match_d = (match_q >= 4'(LOCK_COUNT)) ? 4'(LOCK_COUNT) : match_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SEEK;
      p_q        <= 1'b1;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      hi_hold_q  <= '0;
      hi_sat_q   <= 1'b0;
      match_q    <= 4'd0;
      high_width <= '0;
      low_width  <= '0;
      period     <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      p_q   <= pulse_in;
      valid <= 1'b0;
      case (state_q)
        SEEK: begin
          if (rise) begin
            cnt_q   <= W'(1);
            sat_q   <= 1'b0;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_hold_q <= cnt_q;
            hi_sat_q  <= sat_q;
            cnt_q     <= W'(1);
            sat_q     <= 1'b0;
            state_q   <= LOW;
          end else if (pulse_in) begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end
        end
        LOW: begin
          // The rise that closes the low phase both reports the cycle and opens the next one.
          if (rise) begin
            high_width <= hi_hold_q;
            low_width  <= cnt_q;
            period     <= period_d;
            ovf        <= ovf_d;
            valid      <= 1'b1;
            match_q    <= match_d;
            locked     <= (match_d == 4'(LOCK_COUNT));
            cnt_q      <= W'(1);
            sat_q      <= 1'b0;
            state_q    <= HIGH;
          end else if (!pulse_in) begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

endmodule
